poly_add_ctrl: RTL and testbench
================================

POLY_ADD_CTRL -- requirements
Module: poly_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 12, coefficient width in bits.
REQ-002 Parameter N, default 256, coefficients per polynomial.
REQ-003 Parameter AW, default 8, address width; N SHALL equal 2**AW.
REQ-004 Parameter Q, default 3329, modulus; the block SHALL be used only with Q = 3329.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset; synchronous and active-low.
REQ-007 start  in  1  one-cycle request to process one polynomial pair.
REQ-008 busy  out  1  high from start acceptance until the cycle before done.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 rd_en  out  1  read strobe, shared by operand banks A and B.
REQ-011 rd_addr  out  AW  coefficient index read from both banks.
REQ-012 a_rdata  in  WIDTH  bank A data, valid exactly one cycle after rd_en.
REQ-013 b_rdata  in  WIDTH  bank B data, valid exactly one cycle after rd_en.
REQ-014 wr_en  out  1  result write strobe.
REQ-015 wr_addr  out  AW  result coefficient index.
REQ-016 wr_data  out  WIDTH  (a + b) mod Q.

Function
REQ-017 FSM states SHALL be IDLE, READ, DRAIN and DONE.
REQ-018 IDLE: start=1 SHALL move to READ next cycle with the read counter at 0 and busy=1.
REQ-019 READ: rd_en=1 and rd_addr=counter; the counter SHALL increment by 1 per cycle.
REQ-020 READ: after issuing rd_addr=N-1, the FSM SHALL go to DRAIN with no counter wrap-around read.
REQ-021 DRAIN SHALL last exactly 2 cycles, with rd_en=0.
REQ-022 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-023 Pipeline: a_rdata/b_rdata captured in the cycle after rd_en SHALL be summed, reduced and registered.
REQ-024 wr_en/wr_addr/wr_data SHALL appear 2 cycles after the corresponding rd_en/rd_addr.
REQ-025 Timing: start accepted at edge t; rd_en high in cycles t+1..t+N.
REQ-026 Timing (continued): wr_en high in cycles t+3..t+N+2; done in cycle t+N+3; total N+3 cycles.
REQ-027 Arithmetic: s = a + b in WIDTH+1 bits.
REQ-028 Arithmetic (continued): if s >= Q, subtract Q; then if the result >= Q, subtract Q again; wr_data is the low WIDTH bits.
REQ-029 Any WIDTH-bit inputs, including non-canonical values up to 4095, SHALL yield wr_data < Q.
REQ-030 wr_addr SHALL be strictly increasing 0..N-1 with no gaps or repeats.
REQ-031 start while busy=1 or done=1 SHALL be ignored, with no effect on counters or outputs.
REQ-032 start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-033 Outside the listed cycles, rd_en and wr_en SHALL be 0; wr_data and rd_addr hold their last value.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE and clear the counter and all pipeline valid bits.
REQ-035 During reset, busy, done, rd_en, wr_en SHALL be 0; rd_addr, wr_addr, wr_data SHALL be 0.
REQ-036 Reset mid-operation SHALL suppress all further wr_en from the aborted job and produce no done pulse.
REQ-037 After rst_n returns high, the block SHALL be in IDLE and accept start on the first cycle.

Verification
REQ-038 Full run, A[i]=i, B[i]=3328 -> wr_data[i]=(i+3328) mod 3329 (=i-1 for i>=1, 3328 for i=0); 256 writes; done at t+259.
REQ-039 Boundary sums, A=3328,B=1 -> 0; A=1664,B=1665 -> 0; A=3328,B=3328 -> 3327; A=0,B=0 -> 0.
REQ-040 Non-canonical inputs, A=4095,B=4095 -> 1532; A=4095,B=0 -> 766; every output < 3329.
REQ-041 Start pulsed every cycle during a job -> exactly one job executed; the next start, issued the cycle after done, runs a second job with identical timing.
REQ-042 rst_n=0 at cycle t+100 -> no wr_en or done afterward; outputs 0; a new start after release completes a normal 256-write job.
REQ-043 Scoreboard on every run -> wr_addr sequence 0..255 exactly once; wr_en count 256; busy high for cycles t+1..t+N+2 only.

Source files
------------

// File: rtl/poly_add_ctrl_if.sv
// Handshake and operand/result bus for poly_add_ctrl: job control, shared
// A/B bank read port and result write port.
interface poly_add_ctrl_if #(
    parameter int WIDTH = 12,
    parameter int AW    = 8
);
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] a_rdata;
    logic [WIDTH-1:0] b_rdata;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Controller side: takes job requests and operand data, drives strobes.
    modport slave (
        input  start, a_rdata, b_rdata,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    // System side: issues jobs, serves the operand banks, sinks results.
    modport master (
        output start, a_rdata, b_rdata,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/poly_add_ctrl.sv
// Streams N coefficient pairs out of banks A and B and writes (a + b) mod Q
// back, two cycles behind each read; one job per accepted start pulse.
module poly_add_ctrl #(
    parameter int WIDTH = 12,
    parameter int N     = 256,
    parameter int AW    = 8,
    parameter int Q     = 3329
) (
    input  logic          clk,
    input  logic          rst_n,
    poly_add_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH:0]  Q_EXT     = (WIDTH+1)'(Q);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(N - 1);
    localparam logic [AW-1:0]   ADDR_ONE  = AW'(1);

    // Two conditional subtractions cover any pair of WIDTH-bit inputs, since
    // their sum stays below 3*Q even when both operands are non-canonical.
    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s0;
        logic [WIDTH:0] s1;
        logic [WIDTH:0] s2;
        s0 = {1'b0, a} + {1'b0, b};
        s1 = (s0 >= Q_EXT) ? (s0 - Q_EXT) : s0;
        s2 = (s1 >= Q_EXT) ? (s1 - Q_EXT) : s1;
        return s2[WIDTH-1:0];
    endfunction

    state_t           state_q,   state_d;
    logic [AW-1:0]    cnt_q,     cnt_d;
    logic             drain_q,   drain_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             rd_en_q,   rd_en_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             s1_vld_q,  s1_vld_d;
    logic [AW-1:0]    s1_addr_q, s1_addr_d;
    logic             wr_en_q,   wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;

    // Sequencer next-state: outputs are computed for the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d   = ST_READ;
                    cnt_d     = {AW{1'b0}};
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = {AW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q + ADDR_ONE;
                    rd_en_d   = 1'b1;
                    rd_addr_d = cnt_q + ADDR_ONE;
                end
            end
            ST_DRAIN: begin
                busy_d = 1'b1;
                if (drain_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next-state: stage 1 tracks the read in flight, stage 2 writes.
    always_comb begin
        s1_vld_d  = rd_en_q;
        s1_addr_d = s1_addr_q;
        wr_en_d   = s1_vld_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (rd_en_q) begin
            s1_addr_d = rd_addr_q;
        end else begin
            s1_addr_d = s1_addr_q;
        end
        if (s1_vld_q) begin
            wr_addr_d = s1_addr_q;
            wr_data_d = mod_add(bus.a_rdata, bus.b_rdata);
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // State and output registers; reset also drops any write still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {AW{1'b0}};
            drain_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= {AW{1'b0}};
            s1_vld_q  <= 1'b0;
            s1_addr_q <= {AW{1'b0}};
            wr_en_q   <= 1'b0;
            wr_addr_q <= {AW{1'b0}};
            wr_data_q <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_poly_add_ctrl.sv
// Bench for poly_add_ctrl: bank model, per-cycle job timeline expectations
// and modular-sum reference computed with the % operator.
module tb_poly_add_ctrl;
    localparam int WIDTH = 12;
    localparam int N     = 256;
    localparam int AW    = 8;
    localparam int Q     = 3329;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    poly_add_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    poly_add_ctrl #(.WIDTH(WIDTH), .N(N), .AW(AW), .Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned mem_a [N];
    int unsigned mem_b [N];
    int unsigned exp_w [N];
    int unsigned bnd_a [6] = '{3328, 1664, 3328, 0, 4095, 4095};
    int unsigned bnd_b [6] = '{1,    1665, 3328, 0, 4095, 0};
    int unsigned bnd_e [6] = '{0,    0,    3327, 0, 1532, 766};
    int n_checks = 0;
    int n_fail   = 0;

    // Bank model: one-cycle read latency, garbage whenever no read was issued.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.a_rdata <= WIDTH'(mem_a[bus.rd_addr]);
            bus.b_rdata <= WIDTH'(mem_b[bus.rd_addr]);
        end else begin
            bus.a_rdata <= WIDTH'($urandom);
            bus.b_rdata <= WIDTH'($urandom);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: A=i, B=3328; 1: random 12-bit; 2: boundary table; else random canonical
    task automatic fill(input int mode);
        int unsigned a, b, e;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: begin a = i; b = 3328; e = (i == 0) ? 3328 : i - 1; end
                1: begin a = $urandom_range(4095, 0); b = $urandom_range(4095, 0); e = (a + b) % Q; end
                2: begin a = bnd_a[i % 6]; b = bnd_b[i % 6]; e = bnd_e[i % 6]; end
                default: begin a = $urandom_range(Q - 1, 0); b = $urandom_range(Q - 1, 0); e = (a + b) % Q; end
            endcase
            mem_a[i] = a;
            mem_b[i] = b;
            exp_w[i] = e;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},    bus.busy,    0);
        check_eq({tag, "_done"},    bus.done,    0);
        check_eq({tag, "_rd_en"},   bus.rd_en,   0);
        check_eq({tag, "_wr_en"},   bus.wr_en,   0);
        check_eq({tag, "_rd_addr"}, bus.rd_addr, 0);
        check_eq({tag, "_wr_addr"}, bus.wr_addr, 0);
        check_eq({tag, "_wr_data"}, bus.wr_data, 0);
    endtask

    // Starts a job in the current (IDLE) cycle and checks cycles t+1..t+N+3;
    // abort_k > 0 asserts reset during cycle t+abort_k and returns early.
    task automatic run_job(input bit spam, input int abort_k);
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= N + 3; k++) begin
            @(negedge clk);
            bus.start = spam;
            check_eq($sformatf("busy@%0d", k),  bus.busy,  (k <= N + 2) ? 1 : 0);
            check_eq($sformatf("done@%0d", k),  bus.done,  (k == N + 3) ? 1 : 0);
            check_eq($sformatf("rd_en@%0d", k), bus.rd_en, (k <= N) ? 1 : 0);
            check_eq($sformatf("wr_en@%0d", k), bus.wr_en, (k >= 3 && k <= N + 2) ? 1 : 0);
            if (k <= N) begin
                check_eq($sformatf("rd_addr@%0d", k), bus.rd_addr, k - 1);
            end else begin
                check_eq($sformatf("rd_addr_hold@%0d", k), bus.rd_addr, N - 1);
            end
            if (k >= 3 && k <= N + 2) begin
                check_eq($sformatf("wr_addr@%0d", k), bus.wr_addr, k - 3);
                check_eq($sformatf("wr_data@%0d", k), bus.wr_data, exp_w[k - 3]);
                check_eq($sformatf("wr_lt_q@%0d", k), (bus.wr_data < Q) ? 1 : 0, 1);
            end else if (k > N + 2) begin
                check_eq("wr_addr_hold", bus.wr_addr, N - 1);
                check_eq("wr_data_hold", bus.wr_data, exp_w[N - 1]);
            end
            if (k == abort_k) begin
                bus.start = 1'b0;
                rst_n     = 1'b0;
                return;
            end
        end
        @(negedge clk);
        check_eq("post_busy",  bus.busy,  0);
        check_eq("post_rd_en", bus.rd_en, 0);
        check_eq("post_done",  bus.done,  0);
        bus.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        rst_n     = 1'b0;
        fill(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        run_job(1'b0, 0);

        repeat (3) @(negedge clk);
        fill(2);
        run_job(1'b0, 0);

        repeat (2) @(negedge clk);
        fill(1);
        run_job(1'b0, 0);

        repeat (2) @(negedge clk);
        fill(3);
        run_job(1'b1, 0);
        run_job(1'b0, 0);

        repeat (2) @(negedge clk);
        fill(1);
        run_job(1'b0, 100);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_all_zero($sformatf("abort%0d", c));
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq($sformatf("rel_wr_en%0d", c), bus.wr_en, 0);
            check_eq($sformatf("rel_done%0d", c),  bus.done,  0);
            check_eq($sformatf("rel_busy%0d", c),  bus.busy,  0);
        end
        fill(0);
        run_job(1'b0, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
